// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester, transmitter and status signals of the UART byte arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface uart_tx_arb_if;
    logic [3:0]  i_req;
    logic [31:0] i_req_byte;
    logic [3:0]  o_grant;
    logic [3:0]  o_done;
    logic        o_busy;
    logic [7:0]  o_byte;
    logic        o_data_valid;
    logic        i_tx_active;
    logic        i_tx_done;
    logic        o_timeout;

    modport slave (
        input  i_req, i_req_byte, i_tx_active, i_tx_done,
        output o_grant, o_done, o_busy, o_byte, o_data_valid, o_timeout
    );

    modport master (
        output i_req, i_req_byte, i_tx_active, i_tx_done,
        input  o_grant, o_done, o_busy, o_byte, o_data_valid, o_timeout
    );
endinterface

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter handing one byte at a time from four requesters to a
// single UART transmitter, then waiting for the frame (start, data, stop) to finish.
// Optional transaction watchdog: define UART_TX_ARB_TIMEOUT_EN to enable it.
module uart_tx_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 2047
) (
    input  logic         i_uart_clk,
    input  logic         i_rst_n,
    uart_tx_arb_if.slave bus
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 4095) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must lie in 2..4095");
    end

    typedef enum logic [1:0] {StIdle, StWaitStart, StWaitDone, StWaitIdle} state_e;

    state_e     state_q, state_d;
    logic [1:0] last_q, last_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] pick, cand;
    logic [7:0] byte_q, byte_d;
    logic [3:0] grant_q, grant_d;
    logic [3:0] done_q, done_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       timeout_q, timeout_d;
    logic       start;
    logic       expire;

    assign start = (state_q == StIdle) && (|bus.i_req);

    // Round-robin pick: scan downward so the lowest offset past last winner is written last.
    always_comb begin
        pick = last_q;
        cand = last_q;
        for (int i = 4; i >= 1; i--) begin
            cand = last_q + 2'(i);
            if (bus.i_req[cand]) pick = cand;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [11:0] WdogLast = 12'(TIMEOUT_CYCLES - 2);
    logic [11:0] wdog_q, wdog_d;

    // Watchdog counter: cleared by a grant, counts every cycle of an open transaction.
    always_comb begin
        wdog_d = wdog_q;
        if (start) begin
            wdog_d = '0;
        end else if (state_q != StIdle) begin
            wdog_d = wdog_q + 12'd1;
        end
    end

    // Fire as the count reaches TIMEOUT_CYCLES-1, unless the frame completes on this edge.
    assign expire = (state_q != StIdle) && (wdog_q == WdogLast) &&
                    !((state_q == StWaitIdle) && !bus.i_tx_done);

    // Watchdog counter register.
    always_ff @(posedge i_uart_clk) begin
        if (!i_rst_n) wdog_q <= '0;
        else          wdog_q <= wdog_d;
    end
`else
    assign expire = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_uart_clk) begin
        if (!i_rst_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic; a watchdog abort overrides any normal transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:      if (|bus.i_req)      state_d = StWaitStart;
            StWaitStart: if (bus.i_tx_active) state_d = StWaitDone;
            StWaitDone:  if (bus.i_tx_done)   state_d = StWaitIdle;
            StWaitIdle:  if (!bus.i_tx_done)  state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
        if (expire) state_d = StIdle;
    end

    // Next values of the registered outputs and arbitration bookkeeping.
    always_comb begin
        grant_d   = '0;
        valid_d   = 1'b0;
        done_d    = '0;
        byte_d    = byte_q;
        winner_d  = winner_q;
        last_d    = last_q;
        timeout_d = expire;
        busy_d    = (state_d != StIdle);
        if (start) begin
            winner_d = pick;
            last_d   = pick;
            byte_d   = bus.i_req_byte[{pick, 3'b000} +: 8];
            grant_d  = 4'b0001 << pick;
            valid_d  = 1'b1;
        end
        if ((state_q == StWaitIdle) && !bus.i_tx_done && !expire) begin
            done_d = 4'b0001 << winner_q;
        end
    end

    // Output and bookkeeping registers; last winner resets to 3 so requester 0 wins first.
    always_ff @(posedge i_uart_clk) begin
        if (!i_rst_n) begin
            grant_q   <= '0;
            valid_q   <= 1'b0;
            done_q    <= '0;
            byte_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            winner_q  <= 2'd0;
            last_q    <= 2'd3;
        end else begin
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            byte_q    <= byte_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            winner_q  <= winner_d;
            last_q    <= last_d;
        end
    end

    assign bus.o_grant      = grant_q;
    assign bus.o_data_valid = valid_q;
    assign bus.o_done       = done_q;
    assign bus.o_byte       = byte_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_timeout    = timeout_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized and directed checks of uart_tx_arb against a transaction-level
// round-robin model and a behavioural UART transmitter timing model.
module tb_uart_tx_arb;

    localparam int unsigned Tmo = 2047;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arb_if bus ();

    uart_tx_arb #(.TIMEOUT_CYCLES(Tmo)) dut (
        .i_uart_clk (clk),
        .i_rst_n    (rst_n),
        .bus        (bus)
    );

    int vectors = 0;
    int errors  = 0;
    int baud    = 3;
    bit tx_hold = 1'b0;
    int model_last = 3;
    logic [7:0] req_bytes [4];

    // Transmitter model: after a start pulse, 9 bit-times active (start+data), 1 bit-time stop.
    initial begin
        int cnt;
        cnt = 0;
        bus.i_tx_active = 1'b0;
        bus.i_tx_done   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || tx_hold) cnt = 0;
            else if (cnt == 0) begin
                if (bus.o_data_valid) cnt = 1;
            end else begin
                cnt++;
                if (cnt > 10 * baud) cnt = 0;
            end
            bus.i_tx_active = (cnt >= 1) && (cnt <= 9 * baud);
            bus.i_tx_done   = (cnt > 9 * baud);
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running, required to have finished");
        $fatal(1, "time limit");
    end

    function automatic int model_pick(input logic [3:0] req);
        for (int i = 1; i <= 4; i++) begin
            int k;
            k = (model_last + i) % 4;
            if (req[k]) return k;
        end
        return 0;
    endfunction

    task automatic set_bytes();
        bus.i_req_byte = {req_bytes[3], req_bytes[2], req_bytes[1], req_bytes[0]};
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        bus.i_req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_last = 3;
    endtask

    task automatic wait_grant(output logic [3:0] g, output logic [7:0] b, output logic v,
                              output int cyc);
        g = '0; b = '0; v = 1'b0; cyc = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (bus.o_grant != 0) begin
                g = bus.o_grant; b = bus.o_byte; v = bus.o_data_valid; cyc = i;
                return;
            end
        end
    endtask

    task automatic wait_done(output logic [3:0] d, output logic busy, output int cyc);
        d = '0; busy = 1'b1; cyc = -1;
        for (int i = 1; i <= 5000; i++) begin
            @(negedge clk);
            if (bus.o_done != 0) begin
                d = bus.o_done; busy = bus.o_busy; cyc = i;
                return;
            end
        end
    endtask

    task automatic wait_active();
        for (int i = 0; i < 200 && !bus.i_tx_active; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_req = 4'hf;
        @(negedge clk);
        vectors++; if (bus.o_grant !== 4'h0) begin errors++;
            $display("FAIL reset_grant: got %h required 0", bus.o_grant); end
        vectors++; if (bus.o_done !== 4'h0) begin errors++;
            $display("FAIL reset_done: got %h required 0", bus.o_done); end
        vectors++; if (bus.o_busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b required 0", bus.o_busy); end
        vectors++; if (bus.o_byte !== 8'h00) begin errors++;
            $display("FAIL reset_byte: got %h required 00", bus.o_byte); end
        vectors++; if (bus.o_data_valid !== 1'b0) begin errors++;
            $display("FAIL reset_valid: got %b required 0", bus.o_data_valid); end
        vectors++; if (bus.o_timeout !== 1'b0) begin errors++;
            $display("FAIL reset_timeout: got %b required 0", bus.o_timeout); end
        bus.i_req = '0;
        rst_n = 1'b1;
        model_last = 3;
    endtask

    task automatic test_single();
        logic [3:0] g, d; logic [7:0] b; logic v, busy; int cyc;
        apply_reset();
        baud = 139;
        req_bytes[0] = 8'h55; set_bytes();
        bus.i_req = 4'b0001;
        wait_grant(g, b, v, cyc);
        bus.i_req = '0;
        vectors++; if (g !== 4'b0001) begin errors++;
            $display("FAIL single_grant: got %b required 0001", g); end
        vectors++; if (v !== 1'b1 || cyc != 1) begin errors++;
            $display("FAIL single_valid_latency: got valid %b at %0d required 1 at 1", v, cyc); end
        vectors++; if (b !== 8'h55) begin errors++;
            $display("FAIL single_byte: got %h required 55", b); end
        @(negedge clk);
        vectors++; if (bus.o_grant !== 4'h0 || bus.o_data_valid !== 1'b0) begin errors++;
            $display("FAIL single_pulse_width: got grant %b valid %b required 0000 0",
                     bus.o_grant, bus.o_data_valid); end
        wait_done(d, busy, cyc);
        vectors++; if (d !== 4'b0001 || cyc != 10 * baud) begin errors++;
            $display("FAIL single_done: got %b after %0d required 0001 after %0d", d, cyc,
                     10 * baud); end
        vectors++; if (busy !== 1'b0 || bus.o_byte !== 8'h55) begin errors++;
            $display("FAIL single_after: got busy %b byte %h required 0 55", busy, bus.o_byte); end
        @(negedge clk);
        vectors++; if (bus.o_done !== 4'h0) begin errors++;
            $display("FAIL single_done_width: got %b required 0000", bus.o_done); end
    endtask

    task automatic test_fairness();
        logic [3:0] g, d; logic [7:0] b; logic v, busy; int cyc, exp;
        apply_reset();
        baud = 2;
        for (int k = 0; k < 4; k++) req_bytes[k] = 8'hA0 + 8'(k);
        set_bytes();
        bus.i_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(g, b, v, cyc);
            exp = model_pick(bus.i_req);
            model_last = exp;
            if (n == 4) bus.i_req = '0;
            vectors++; if (g !== (4'b0001 << exp) || b !== req_bytes[exp]) begin errors++;
                $display("FAIL fair_grant%0d: got %b/%h required %b/%h", n, g, b,
                         4'b0001 << exp, req_bytes[exp]); end
            if (n > 0) begin
                vectors++; if (cyc != 1) begin errors++;
                    $display("FAIL fair_gap%0d: got %0d cycles required 1", n, cyc); end
            end
            wait_done(d, busy, cyc);
            vectors++; if (d !== g) begin errors++;
                $display("FAIL fair_done%0d: got %b required %b", n, d, g); end
        end
    endtask

    task automatic test_wrap();
        logic [3:0] g, d; logic [7:0] b; logic v, busy; int cyc, exp;
        logic [3:0] seq [3];
        seq[0] = 4'b1000; seq[1] = 4'b0100; seq[2] = 4'b1000;
        for (int n = 0; n < 3; n++) begin
            bus.i_req = seq[n];
            wait_grant(g, b, v, cyc);
            bus.i_req = '0;
            exp = model_pick(seq[n]);
            model_last = exp;
            vectors++; if (g !== (4'b0001 << exp)) begin errors++;
                $display("FAIL wrap_grant%0d: got %b required %b", n, g, 4'b0001 << exp); end
            wait_done(d, busy, cyc);
        end
    endtask

    task automatic test_busy_ignore();
        logic [3:0] g, d; logic [7:0] b; logic v, busy; int cyc;
        bit early, seen;
        bus.i_req = 4'b0001;
        wait_grant(g, b, v, cyc);
        bus.i_req = '0;
        model_last = 0;
        wait_active();
        bus.i_req = 4'b0010;
        early = 1'b0; seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (bus.o_grant != 0) early = 1'b1;
            if (bus.o_done != 0) seen = 1'b1;
        end
        vectors++; if (early || !seen) begin errors++;
            $display("FAIL busy_ignore: got early grant %b done seen %b required 0 1", early,
                     seen); end
        wait_grant(g, b, v, cyc);
        bus.i_req = '0;
        model_last = 1;
        vectors++; if (g !== 4'b0010 || cyc != 1) begin errors++;
            $display("FAIL busy_next_grant: got %b after %0d required 0010 after 1", g, cyc); end
        wait_done(d, busy, cyc);
    endtask

    task automatic test_reset_mid();
        logic [3:0] g, d; logic [7:0] b; logic v, busy; int cyc;
        bit stray;
        bus.i_req = 4'b0100;
        wait_grant(g, b, v, cyc);
        bus.i_req = '0;
        wait_active();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 3;
        vectors++; if ({bus.o_grant, bus.o_done, bus.o_busy, bus.o_byte, bus.o_data_valid,
                        bus.o_timeout} !== 19'd0) begin errors++;
            $display("FAIL midreset_outputs: got g%b d%b busy%b byte%h v%b t%b required all 0",
                     bus.o_grant, bus.o_done, bus.o_busy, bus.o_byte, bus.o_data_valid,
                     bus.o_timeout); end
        stray = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.o_done != 0 || bus.o_timeout || bus.o_busy) stray = 1'b1;
        end
        vectors++; if (stray) begin errors++;
            $display("FAIL midreset_quiet: got activity after reset required none"); end
        bus.i_req = 4'b1111;
        wait_grant(g, b, v, cyc);
        bus.i_req = '0;
        model_last = 0;
        vectors++; if (g !== 4'b0001) begin errors++;
            $display("FAIL midreset_first: got %b required 0001", g); end
        wait_done(d, busy, cyc);
    endtask

    task automatic test_random();
        logic [3:0] g, d; logic [7:0] b; logic v, busy; int cyc, exp;
        logic [3:0] req_cur;
        apply_reset();
        req_cur = '0;
        for (int t = 0; t < 24; t++) begin
            if (req_cur == 0) begin
                req_cur = 4'($urandom_range(1, 15));
                for (int k = 0; k < 4; k++) req_bytes[k] = 8'($urandom);
                set_bytes();
            end
            baud = int'($urandom_range(1, 4));
            bus.i_req = req_cur;
            wait_grant(g, b, v, cyc);
            exp = model_pick(req_cur);
            model_last = exp;
            req_cur[exp] = 1'b0;
            bus.i_req = req_cur;
            vectors++; if (g !== (4'b0001 << exp) || b !== req_bytes[exp] || v !== 1'b1)
            begin errors++;
                $display("FAIL rand_grant%0d: got %b/%h/%b required %b/%h/1", t, g, b, v,
                         4'b0001 << exp, req_bytes[exp]); end
            wait_done(d, busy, cyc);
            vectors++; if (d !== g || busy !== 1'b0) begin errors++;
                $display("FAIL rand_done%0d: got %b busy %b required %b busy 0", t, d, busy,
                         g); end
        end
        bus.i_req = '0;
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [3:0] g; logic [7:0] b; logic v; int cyc;
        bit got, done_seen;
        apply_reset();
        tx_hold = 1'b1;
        bus.i_req = 4'b0001;
        wait_grant(g, b, v, cyc);
        bus.i_req = '0;
        got = 1'b0; done_seen = 1'b0; cyc = -1;
        for (int i = 1; i <= int'(Tmo) + 20 && !got; i++) begin
            @(negedge clk);
            if (bus.o_done != 0) done_seen = 1'b1;
            if (bus.o_timeout) begin got = 1'b1; cyc = i; end
        end
        vectors++; if (cyc != int'(Tmo) - 1 || done_seen || bus.o_busy !== 1'b0) begin errors++;
            $display("FAIL timeout: got pulse at %0d done %b busy %b required %0d 0 0", cyc,
                     done_seen, bus.o_busy, int'(Tmo) - 1); end
        tx_hold = 1'b0;
    endtask
`endif

    initial begin
        bus.i_req = '0;
        bus.i_req_byte = '0;
        for (int k = 0; k < 4; k++) req_bytes[k] = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_busy_ignore();
        test_reset_mid();
        test_random();
`ifdef UART_TX_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
- REQ-001 Parameter TIMEOUT_CYCLES, default 2047: transaction watchdog limit in clocks. Used only when UART_TX_ARB_TIMEOUT_EN is defined; legal range 2..4095.
- REQ-002 i_uart_clk  input  1  single clock for the whole block; all logic SHALL be clocked on its rising edge.
- REQ-003 i_rst_n  input  1  reset, synchronous, active-low.
- REQ-004 i_req  input  4  request bit per requester k (0..3); held high until that requester's o_grant[k] is seen.
- REQ-005 i_req_byte  input  32  requester k's byte on bits [8k+7:8k]; stable while i_req[k] is high.
- REQ-006 o_grant  output  4  one-hot, one-cycle pulse: requester k's byte was captured.
- REQ-007 o_done  output  4  one-hot, one-cycle pulse: requester k's byte has finished its stop bit.
- REQ-008 o_busy  output  1  high in every state except IDLE.
- REQ-009 o_byte  output  8  byte presented to the transmitter.
- REQ-010 o_data_valid  output  1  one-cycle start pulse to the transmitter.
- REQ-011 i_tx_active  input  1  transmitter active flag, high during start and data bits.
- REQ-012 i_tx_done  input  1  transmitter stop-bit flag, high for the whole stop bit.
- REQ-013 o_timeout  output  1  one-cycle watchdog abort pulse; tied 0 when the macro is undefined.

Function
- REQ-014 State machine: IDLE -> WAIT_START -> WAIT_DONE -> WAIT_IDLE -> IDLE. All outputs SHALL be registered.
- REQ-015 IDLE with i_req != 0, evaluated at a clock edge, SHALL make all of the following take effect at that same edge:
  - the winner is selected and stored;
  - o_byte is loaded with the winner's byte;
  - o_data_valid goes to 1 and o_grant[winner] goes to 1;
  - the state moves to WAIT_START.
  Latency from request sampled to grant is therefore 1 clock.
- REQ-016 o_data_valid and o_grant SHALL return to 0 on the next edge; each SHALL be high for exactly 1 cycle.
- REQ-017 Winner selection is round-robin. The search starts at index (last_winner+1) mod 4, ascends, wraps 3->0, and the first requester with i_req set wins.
- REQ-018 last_winner SHALL update only when a grant is issued.
- REQ-019 In any state other than IDLE, i_req SHALL be ignored. No grant and no pointer change occur outside IDLE.
- REQ-020 WAIT_START SHALL move to WAIT_DONE on the first edge where i_tx_active=1.
- REQ-021 WAIT_DONE SHALL move to WAIT_IDLE on the first edge where i_tx_done=1.
- REQ-022 WAIT_IDLE SHALL move to IDLE on the first edge where i_tx_done=0, and at the same edge SHALL pulse o_done[winner] for 1 cycle.
- REQ-023 The first IDLE cycle SHALL already be able to grant; back-to-back bytes therefore have no extra gap.
- REQ-024 o_byte SHALL hold its value from grant until the next grant.
- REQ-025 A requester whose i_req is still high on return to IDLE SHALL be treated as a new byte.

Reset
- REQ-026 While i_rst_n=0 at an edge, the block SHALL reset to:
  - state IDLE;
  - o_grant=0, o_done=0, o_busy=0, o_byte=0, o_data_valid=0, o_timeout=0;
  - last_winner=3, so requester 0 wins first;
  - watchdog counter=0.
- REQ-027 A reset during any transaction SHALL abort it immediately, with no o_done pulse and no o_timeout pulse.

Configuration
- REQ-028 With UART_TX_ARB_TIMEOUT_EN defined, a 12-bit counter SHALL do the following:
  - clear on each grant;
  - increment once per cycle in WAIT_START, WAIT_DONE and WAIT_IDLE;
  - on reaching TIMEOUT_CYCLES-1 without completing, force the state to IDLE, pulse o_timeout for 1 cycle, and suppress o_done.
- REQ-029 With UART_TX_ARB_TIMEOUT_EN undefined, there SHALL be no counter and o_timeout SHALL be constant 0. The block then waits indefinitely in each state.

Verification
- REQ-030 Single request, transmitter model with BAUD_MULT=139:
  - stimulus: i_req=0001, byte 0x55;
  - response: o_grant=0001 and o_data_valid pulse 1 clock after the request; o_byte=0x55; o_done=0001 after the stop bit; o_busy low afterwards.
- REQ-031 Fairness:
  - stimulus: i_req=1111 held continuously after reset, bytes 0xA0..0xA3;
  - response: grant order 0,1,2,3,0 and bytes in the order 0xA0,0xA1,0xA2,0xA3.
- REQ-032 Wrap and skip:
  - stimulus: last winner 3, then i_req=0100;
  - response: requester 2 is granted, not skipped; then a single i_req=1000 grants requester 3.
- REQ-033 Ignore requests while busy:
  - stimulus: assert i_req=0010 while in WAIT_DONE;
  - response: no grant until the cycle after the o_done pulse.
- REQ-034 Reset mid-transaction:
  - stimulus: pull i_rst_n low for 1 clock during WAIT_DONE;
  - response: every output is 0, no o_done pulse, and the next grant goes to requester 0.
- REQ-035 Watchdog, macro defined, TIMEOUT_CYCLES=16:
  - stimulus: hold i_tx_active=0;
  - response: o_timeout pulses 15 clocks after the grant, state returns to IDLE, no o_done pulse.
